// File: rtl/vpop_pkg.sv
// Shared types and constants for the vector pop-count / parity / LZC unit.
package vpop_pkg;

   localparam logic [2:0] MODE_POP = 3'b001;
   localparam logic [2:0] MODE_PAR = 3'b010;
   localparam logic [2:0] MODE_LZC = 3'b011;

   // Element index carried in the pipeline tag; covers vector lengths up to 64.
   localparam int TAG_IDX_W = 6;

   typedef struct packed {
      logic                 valid;
      logic [2:0]           mode;
      logic [TAG_IDX_W-1:0] idx;
      logic                 last;
   } vpop_tag_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_EMPTY = 2'd3
   } vpop_state_t;

   // Count width able to hold 0..dw inclusive.
   function automatic int calc_cnt_w(input int dw);
      return $clog2(dw + 1);
   endfunction

   function automatic int calc_stages(input int dw, input int cw);
      return dw / cw;
   endfunction

endpackage

// File: rtl/vpop_lzc_stage.sv
// One chunk slice of the pipeline: adds the chunk pop count, or extends the
// running leading-zero count until the first set bit has been found.
module vpop_lzc_stage
   import vpop_pkg::*;
#(
   parameter int CHUNK_W = 16,
   parameter int CNT_W   = 7
)(
   input  logic               lzc,
   input  logic [CHUNK_W-1:0] chunk,
   input  logic [CNT_W-1:0]   cnt_i,
   input  logic               found_i,
   output logic [CNT_W-1:0]   cnt_o,
   output logic               found_o
);

   logic [CNT_W-1:0] pop;
   logic [CNT_W-1:0] lz;
   logic             hit;

   // Chunk population count and leading zeros (MSB first), then merge.
   always_comb begin
      pop = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         pop = pop + CNT_W'(chunk[i]);
      end
      lz  = CNT_W'(CHUNK_W);
      hit = 1'b0;
      for (int i = CHUNK_W - 1; i >= 0; i--) begin
         if (!hit && chunk[i]) begin
            lz  = CNT_W'(CHUNK_W - 1 - i);
            hit = 1'b1;
         end
      end
      if (lzc) begin
         if (found_i) begin
            cnt_o   = cnt_i;
            found_o = 1'b1;
         end else begin
            cnt_o   = cnt_i + lz;
            found_o = hit;
         end
      end else begin
         cnt_o   = cnt_i + pop;
         found_o = found_i;
      end
   end

endmodule

// File: rtl/vector_pop_lzc_unit.sv
// Vector pop count / parity / leading-zero count unit. Streams one element
// per cycle through a chunked pipeline; each element carries its own mode tag.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | unit free, start accepted
//   ST_ISSUE | sampling one element per cycle into the input register
//   ST_DRAIN | all elements issued, waiting for the last result to show
//   ST_EMPTY | zero-length operation, one busy cycle then back to idle
module vector_pop_lzc_unit
   import vpop_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int CHUNK_W  = 16,
   parameter int NUM_VREG = 8,
   parameter int MAX_VL   = 64,
   parameter int VL_W     = 7
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_start,
   input  logic [2:0]                   i_k,
   input  logic [$clog2(NUM_VREG)-1:0]  i_j,
   input  logic [VL_W-1:0]              i_vl,
   input  logic [NUM_VREG*DATA_W-1:0]   i_vdata,
   output logic                         o_start_ack,
   output logic                         o_busy,
   output logic                         o_valid,
   output logic                         o_last,
   output logic [$clog2(MAX_VL)-1:0]    o_elem_idx,
   output logic [DATA_W-1:0]            o_result
);

   localparam int STAGES = calc_stages(DATA_W, CHUNK_W);
   localparam int CNT_W  = calc_cnt_w(DATA_W);
   localparam int J_W    = $clog2(NUM_VREG);
   localparam int IDX_W  = $clog2(MAX_VL);
   localparam logic [VL_W-1:0] MAX_VL_V = VL_W'(MAX_VL);

   vpop_state_t      state_q, state_d;
   logic             accept, issue, issue_last;
   logic [2:0]       k_q;
   logic [J_W-1:0]   j_q;
   logic [VL_W-1:0]  vl_q, cnt_q, eff_vl;

   // Pipeline: index 0 is the input register, index STAGES drives the outputs.
   vpop_tag_t        tag_p   [0:STAGES];
   logic [DATA_W-1:0] data_p [0:STAGES-1];
   logic [CNT_W-1:0] cnt_p   [1:STAGES];
   logic             found_p [1:STAGES];
   logic [CNT_W-1:0] cnt_d   [0:STAGES-1];
   logic             found_d [0:STAGES-1];
   vpop_tag_t        out_tag;

   assign eff_vl     = (i_vl > MAX_VL_V) ? MAX_VL_V : i_vl;
   assign issue_last = (cnt_q == vl_q - 1'b1);
   assign out_tag    = tag_p[STAGES];

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_start) state_d = (eff_vl == '0) ? ST_EMPTY : ST_ISSUE;
         ST_ISSUE: if (issue_last) state_d = ST_DRAIN;
         ST_DRAIN: if (out_tag.valid && out_tag.last) state_d = ST_IDLE;
         ST_EMPTY: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State decode: reservation, issue enable and start acceptance.
   always_comb begin
      o_busy = (state_q != ST_IDLE);
      issue  = (state_q == ST_ISSUE);
      accept = i_start && (state_q == ST_IDLE);
   end

   assign o_start_ack = i_start & ~o_busy;

   // Latch the command on accept; count issued elements.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q   <= '0;
         j_q   <= '0;
         vl_q  <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         k_q   <= i_k;
         j_q   <= i_j;
         vl_q  <= eff_vl;
         cnt_q <= '0;
      end else if (issue) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Input register and stage registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s <= STAGES; s++) tag_p[s] <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_p[s]    <= '0;
            cnt_p[s+1]   <= '0;
            found_p[s+1] <= 1'b0;
         end
      end else begin
         tag_p[0].valid <= issue;
         tag_p[0].mode  <= k_q;
         tag_p[0].idx   <= TAG_IDX_W'(cnt_q);
         tag_p[0].last  <= issue && issue_last;
         data_p[0]      <= i_vdata[j_q*DATA_W +: DATA_W];
         for (int s = 1; s < STAGES; s++) data_p[s] <= data_p[s-1];
         for (int s = 0; s < STAGES; s++) begin
            tag_p[s+1]   <= tag_p[s];
            cnt_p[s+1]   <= cnt_d[s];
            found_p[s+1] <= found_d[s];
         end
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic [CNT_W-1:0]   c_in;
      logic               f_in;
      logic               lzc;
      logic [CHUNK_W-1:0] chunk;

      if (s == 0) begin : g_head
         assign c_in = '0;
         assign f_in = 1'b0;
      end else begin : g_tail
         assign c_in = cnt_p[s];
         assign f_in = found_p[s];
      end

      // LZC walks chunks from the MSB end, the counting modes from the LSB end.
      assign lzc   = (tag_p[s].mode == MODE_LZC);
      assign chunk = lzc ? data_p[s][DATA_W-(s+1)*CHUNK_W +: CHUNK_W]
                         : data_p[s][s*CHUNK_W +: CHUNK_W];

      vpop_lzc_stage #(
         .CHUNK_W (CHUNK_W),
         .CNT_W   (CNT_W)
      ) u_stage (
         .lzc     (lzc),
         .chunk   (chunk),
         .cnt_i   (c_in),
         .found_i (f_in),
         .cnt_o   (cnt_d[s]),
         .found_o (found_d[s])
      );
   end

   assign o_valid    = out_tag.valid;
   assign o_last     = out_tag.last;
   assign o_elem_idx = out_tag.idx[IDX_W-1:0];

   // Result formatting by the element's own mode; zero outside valid cycles.
   always_comb begin
      o_result = '0;
      if (out_tag.valid) begin
         case (out_tag.mode)
            MODE_POP: o_result = DATA_W'(cnt_p[STAGES]);
            MODE_PAR: o_result = DATA_W'(cnt_p[STAGES][0]);
            MODE_LZC: o_result = found_p[STAGES] ? DATA_W'(cnt_p[STAGES])
                                                 : DATA_W'(DATA_W);
            default:  o_result = '0;
         endcase
      end
   end

endmodule

// File: doc/vector_pop_lzc_unit.md
Name: vector_pop_lzc_unit

Overview:
Parametrised successor to the vector population-count/parity functional unit, adding a leading-zero count (LZC) mode. Each cycle it streams one element of the selected vector register through a chunked adder pipeline and returns a per-element result with valid, last and index tags. The mode is carried down the pipeline with each element, and an explicit accept/busy reservation protects the unit. It sits beside the other vector functional units and is driven by the vector issue logic and the vector register read ports.

Parameters:
DATA_W, 64, element width in bits
CHUNK_W, 16, bits consumed per pipeline stage; DATA_W must be a multiple of it
NUM_VREG, 8, number of vector registers presented on i_vdata
MAX_VL, 64, maximum vector length
VL_W, 7, width of i_vl

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_start  in  1  issue request
i_k  in  3  mode select: 001 pop count, 010 parity, 011 LZC
i_j  in  clog2(NUM_VREG)  source vector register
i_vl  in  VL_W  vector length
i_vdata  in  NUM_VREG*DATA_W  current element of each register, flattened; register r at [r*DATA_W +: DATA_W]
o_start_ack  out  1  combinational: i_start & ~o_busy
o_busy  out  1  unit reserved
o_valid  out  1  o_result holds an element result
o_last  out  1  o_valid for the final element
o_elem_idx  out  clog2(MAX_VL)  element index of o_result
o_result  out  DATA_W  zero-extended result

Behaviour:
- Reset (rst=0, asynchronous): all pipeline valids, counters, o_busy, o_valid, o_last, o_elem_idx and o_result clear to 0 immediately. Reset mid-operation aborts the stream; no stale results appear after release.
- Derived constants: STAGES = DATA_W/CHUNK_W; CNT_W = clog2(DATA_W+1).
- Accept: at edge E0 with i_start=1 and o_busy=0, latch i_k, i_j and the effective VL. Effective VL = min(i_vl, MAX_VL). i_start while o_busy=1 is ignored; no state changes.
- Issue: edges E1..E_VL each sample i_vdata[i_j] into the input register, tagged with mode, element index and a last flag.
- Pipeline: stage s (0..STAGES-1) processes chunk s.
  - Pop count and parity: process chunks from LSB upward.
  - Pop count: running CNT_W-bit sum.
  - Parity: XOR of all bits, i.e. pop count bit 0.
  - LZC: process chunks from MSB downward, carrying a count and a found flag. Once found, the count freezes.
  - LZC of an all-zero element is DATA_W.
- Latency: the result for element k is valid in the cycle after edge E(1+k+STAGES). With defaults, VL=1 gives o_valid in the cycle after E5.
- Throughput: one result per cycle, contiguous, no bubbles.
- Result encoding:
  - Pop count and LZC: {zeros, CNT_W-bit count}.
  - Parity: {zeros, parity bit}.
  - Any other i_k: result 0; o_valid, o_last and o_elem_idx still behave normally.
- o_last asserts together with o_valid for element VL-1.
- Busy: o_busy rises the cycle after E0 and stays high through the cycle in which o_last is shown; it falls the next cycle. A new start is accepted at the first edge where o_busy=0.
- VL=0: accepted, no elements issued, no o_valid. o_busy is high for exactly one cycle.
- Per-element mode tagging means back-to-back operations never corrupt each other's mode.

Decomposition:
- Package vpop_pkg:
  - Mode constants: MODE_POP=3'b001, MODE_PAR=3'b010, MODE_LZC=3'b011.
  - CNT_W and STAGES derivation functions.
  - Pipeline tag struct: valid, mode, idx, last.
- Sub-module vpop_lzc_stage: one CHUNK_W slice. It takes the incoming count, found flag and chunk, and outputs the updated count and found flag. It is instantiated STAGES times with a per-stage chunk offset.

Test Plan:
- Pop count, VL=2, i_j=3, elements 0xFFFF_FFFF_FFFF_FFFF then 0x8000_0000_0000_0001 -> results 64 then 2; first o_valid in the cycle after E5; o_last on the second.
- Parity, VL=3, elements 0x7, 0x3, 0x0 -> results 1, 0, 0.
- LZC, VL=3, elements 0x0000_0001_0000_0000, 0x0, 0x8000_0000_0000_0000 -> results 31, 64, 0.
- Busy guard: start VL=3; second start one cycle later -> o_start_ack=0, exactly 3 o_valid pulses, o_elem_idx 0,1,2; o_busy low the cycle after o_last; a fresh start is then accepted.
- Length bounds: i_vl=0 -> no o_valid, o_busy high 1 cycle; i_vl=100 -> exactly 64 results, o_last at idx 63.
- Reset mid-op: VL=64, assert rst=0 between edges during element 10 -> all outputs 0 asynchronously; after release, no o_valid until a new start.
